// File: rtl/decoder_bit_serializer.sv
`default_nettype none

// +----------------------------------------------------------------------------+
// | Module : decoder_bit_serializer                                            |
// | Brief  : Buffers decoded frames in a small FIFO and streams them out one   |
// |          bit per valid/ready transfer, flagging any dropped frame.         |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef DATA_FRAME_LENGTH
`define DATA_FRAME_LENGTH 8
`endif

module decoder_bit_serializer #(
    parameter int unsigned FRAME_LEN = `DATA_FRAME_LENGTH,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [FRAME_LEN-1:0]     i_frame,
    input  logic                     i_frame_valid,
    input  logic                     i_bit_ready,
    output logic                     o_bit,
    output logic                     o_bit_valid,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt,
    output logic                     o_overflow,
    output logic                     o_busy
);

    localparam int unsigned         c_AW       = $clog2(DEPTH);
    localparam int unsigned         c_IW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_IW-1:0]     c_LAST_IDX = c_IW'(FRAME_LEN - 1);
    localparam logic [0:0]          c_ST_IDLE  = 1'b0;
    localparam logic [0:0]          c_ST_SHIFT = 1'b1;

    logic [FRAME_LEN-1:0] r_mem [DEPTH];
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic                 r_overflow;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_IW-1:0]      r_idx;
    logic [c_IW-1:0]      w_idx_nxt;
    logic [c_IW-1:0]      w_sel;
    logic [FRAME_LEN-1:0] r_shift;
    logic [FRAME_LEN-1:0] w_shift_nxt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_xfer;
    logic                 w_last;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push  = i_frame_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_frame_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_frame;
        end
    end

    assign w_xfer = (r_state == c_ST_SHIFT) && en && i_bit_ready;
    assign w_last = (r_state == c_ST_SHIFT) && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr[c_AW-1:0]];
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end else if (!w_empty) begin
                        // Back-to-back frames: reload on the final transfer edge.
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr[c_AW-1:0]];
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sel = c_LAST_IDX - r_idx;
        end else begin : g_lsb_first
            assign w_sel = r_idx;
        end
    endgenerate

    assign o_bit       = r_shift[w_sel];
    assign o_bit_valid = (r_state == c_ST_SHIFT) && en;
    assign o_last      = w_last;
    assign o_fifo_cnt  = r_wr_ptr - r_rd_ptr;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state == c_ST_SHIFT) || (o_fifo_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_decoder_bit_serializer.sv
`default_nettype none

// +----------------------------------------------------------------------------+
// | Module : tb_decoder_bit_serializer                                         |
// | Brief  : Randomized self-checking bench against a frame/bit-queue model.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module tb_decoder_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       i_frame_valid = 1'b0;
    logic       i_bit_ready = 1'b0;
    logic [7:0] i_frame = '0;
    logic       o_bit, o_bit_valid, o_last, o_overflow, o_busy;
    logic [1:0] o_fifo_cnt;

    logic       lsb_frame_valid = 1'b0;
    logic [7:0] lsb_frame = '0;
    logic       lsb_bit, lsb_bit_valid, lsb_last, lsb_overflow, lsb_busy;
    logic [1:0] lsb_fifo_cnt;

    int total = 0;
    int bad   = 0;

    bit obs_bits[$];
    bit obs_last[$];
    bit exp_bits[$];
    bit exp_last[$];
    int obs_cyc[$];
    int cyc = 0;

    logic prev_hold = 1'b0;
    logic prev_bit  = 1'b0;
    logic prev_last = 1'b0;

    always #5 clk = ~clk;

    decoder_bit_serializer #(.FRAME_LEN(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .i_frame(i_frame), .i_frame_valid(i_frame_valid),
        .i_bit_ready(i_bit_ready), .o_bit(o_bit), .o_bit_valid(o_bit_valid), .o_last(o_last),
        .o_fifo_cnt(o_fifo_cnt), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    decoder_bit_serializer #(.FRAME_LEN(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .i_frame(lsb_frame), .i_frame_valid(lsb_frame_valid),
        .i_bit_ready(i_bit_ready), .o_bit(lsb_bit), .o_bit_valid(lsb_bit_valid), .o_last(lsb_last),
        .o_fifo_cnt(lsb_fifo_cnt), .o_overflow(lsb_overflow), .o_busy(lsb_busy)
    );

    // Expected serial order of one frame, most significant bit first.
    task automatic add_exp(input logic [7:0] f);
        for (int k = 0; k < 8; k++) begin
            exp_bits.push_back(bit'((f >> (7 - k)) & 8'd1));
            exp_last.push_back(k == 7);
        end
    endtask

    // One clock: drive inputs, sample pre-edge outputs, log transfers, advance.
    task automatic step(input logic push, input logic [7:0] frm, input logic rdy, input logic en_v);
        i_frame_valid = push;
        i_frame       = frm;
        i_bit_ready   = rdy;
        en            = en_v;
        #1;
        if (prev_hold && en_v) begin
            total++;
            if (o_bit_valid !== 1'b1 || o_bit !== prev_bit || o_last !== prev_last) begin
                bad++;
                $display("FAIL hold_stable: valid=%b bit=%b last=%b required valid=1 bit=%b last=%b",
                         o_bit_valid, o_bit, o_last, prev_bit, prev_last);
            end
        end
        if (o_bit_valid === 1'b1 && rdy) begin
            obs_bits.push_back(o_bit);
            obs_last.push_back(o_last);
            obs_cyc.push_back(cyc);
        end
        prev_hold = (o_bit_valid === 1'b1) && !rdy;
        prev_bit  = o_bit;
        prev_last = o_last;
        @(posedge clk);
        #1;
        i_frame_valid = 1'b0;
        cyc++;
    endtask

    task automatic clear_model();
        obs_bits.delete();
        obs_last.delete();
        obs_cyc.delete();
        exp_bits.delete();
        exp_last.delete();
        prev_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_bit_valid, o_bit, o_last, o_overflow, o_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid,bit,last,ovf,busy=%b required 00000",
                     {o_bit_valid, o_bit, o_last, o_overflow, o_busy});
        end
        total++;
        if (o_fifo_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d required 0", o_fifo_cnt);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        add_exp(8'hA5);
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        total++;
        if (o_bit_valid !== 1'b0 || o_fifo_cnt !== 2'd1) begin
            bad++;
            $display("FAIL single_after_push: valid=%b cnt=%0d required valid=0 cnt=1", o_bit_valid, o_fifo_cnt);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (o_bit_valid !== 1'b1 || o_bit !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: valid=%b bit=%b required valid=1 bit=1", o_bit_valid, o_bit);
        end
        for (int n = 0; n < 20 && obs_bits.size() < 8; n++) step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (obs_bits.size() != 8) begin
            bad++;
            $display("FAIL single_count: got %0d bits required 8", obs_bits.size());
        end
        for (int k = 0; k < 8 && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k] || obs_last[k] !== exp_last[k]) begin
                bad++;
                $display("FAIL single_bit%0d: bit=%b last=%b required bit=%b last=%b",
                         k, obs_bits[k], obs_last[k], exp_bits[k], exp_last[k]);
            end
        end
        total++;
        if (o_bit_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: valid=%b busy=%b required 0 0", o_bit_valid, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] cnt_at [0:16];
        do_reset();
        for (int n = 0; n <= 16; n++) cnt_at[n] = 2'd3;
        add_exp(8'h0F);
        add_exp(8'hF0);
        for (int c = 0; c < 30; c++) begin
            step((c == 0) || (c == 4), (c == 0) ? 8'h0F : 8'hF0, 1'b1, 1'b1);
            if (cnt_at[obs_bits.size()] == 2'd3) cnt_at[obs_bits.size()] = o_fifo_cnt;
        end
        total++;
        if (obs_bits.size() != 16 || (obs_cyc[$] - obs_cyc[0]) != 15) begin
            bad++;
            $display("FAIL b2b_contiguous: bits=%0d span=%0d required 16 bits span 15",
                     obs_bits.size(), (obs_bits.size() > 0) ? obs_cyc[$] - obs_cyc[0] : -1);
        end
        for (int k = 0; k < 16 && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k] || obs_last[k] !== exp_last[k]) begin
                bad++;
                $display("FAIL b2b_bit%0d: bit=%b last=%b required bit=%b last=%b",
                         k, obs_bits[k], obs_last[k], exp_bits[k], exp_last[k]);
            end
        end
        total++;
        if (cnt_at[7] !== 2'd1 || cnt_at[8] !== 2'd0) begin
            bad++;
            $display("FAIL b2b_cnt_switch: before=%0d after=%0d required 1 then 0", cnt_at[7], cnt_at[8]);
        end
    endtask

    task automatic test_ready_toggle();
        logic [7:0] pat;
        pat = 8'b1001_1001;
        do_reset();
        add_exp(8'h3C);
        for (int c = 0; c < 60 && obs_bits.size() < 8; c++)
            step(c == 0, 8'h3C, pat[c % 8], 1'b1);
        total++;
        if (obs_bits.size() != 8) begin
            bad++;
            $display("FAIL toggle_count: got %0d bits required 8", obs_bits.size());
        end
        for (int k = 0; k < 8 && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k]) begin
                bad++;
                $display("FAIL toggle_bit%0d: got %b required %b", k, obs_bits[k], exp_bits[k]);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] f;
        logic       rdy;
        do_reset();
        for (int c = 0; c < 6 * 30 + 40; c++) begin
            f = 8'($urandom);
            if (c % 30 == 0 && c < 6 * 30) add_exp(f);
            rdy = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step((c % 30 == 0) && (c < 6 * 30), f, rdy, 1'b1);
        end
        total++;
        if (obs_bits.size() != exp_bits.size()) begin
            bad++;
            $display("FAIL random_count: got %0d bits required %0d", obs_bits.size(), exp_bits.size());
        end
        for (int k = 0; k < exp_bits.size() && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k] || obs_last[k] !== exp_last[k]) begin
                bad++;
                $display("FAIL random_bit%0d: bit=%b last=%b required bit=%b last=%b",
                         k, obs_bits[k], obs_last[k], exp_bits[k], exp_last[k]);
            end
        end
        total++;
        if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL random_end: ovf=%b busy=%b required 0 0", o_overflow, o_busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] f [4];
        do_reset();
        for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
        // A stalled consumer leaves room for the shifter frame plus DEPTH queued.
        for (int i = 0; i < 3; i++) add_exp(f[i]);
        for (int i = 0; i < 4; i++) step(1'b1, f[i], 1'b0, 1'b1);
        total++;
        if (o_fifo_cnt !== 2'd2 || o_overflow !== 1'b1 || o_busy !== 1'b1 || o_bit_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b busy=%b valid=%b required 2 1 1 1",
                     o_fifo_cnt, o_overflow, o_busy, o_bit_valid);
        end
        for (int n = 0; n < 40 && obs_bits.size() < 24; n++) step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (obs_bits.size() != 24) begin
            bad++;
            $display("FAIL ovf_count: got %0d bits required 24", obs_bits.size());
        end
        for (int k = 0; k < 24 && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k] || obs_last[k] !== exp_last[k]) begin
                bad++;
                $display("FAIL ovf_bit%0d: bit=%b last=%b required bit=%b last=%b",
                         k, obs_bits[k], obs_last[k], exp_bits[k], exp_last[k]);
            end
        end
        total++;
        if (o_overflow !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_sticky: ovf=%b busy=%b required 1 0", o_overflow, o_busy);
        end
    endtask

    // Runs straight after the overflow test so the sticky flag is still set.
    task automatic test_enable_freeze();
        logic [7:0] fa, fb;
        fa = 8'($urandom);
        fb = 8'($urandom);
        clear_model();
        add_exp(fa);
        step(1'b1, fa, 1'b1, 1'b1);
        step(1'b1, fb, 1'b1, 1'b1);
        for (int n = 0; n < 20 && obs_bits.size() < 3; n++) step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (o_bit !== exp_bits[3] || o_fifo_cnt !== 2'd1) begin
            bad++;
            $display("FAIL freeze_at_bit3: bit=%b cnt=%0d required bit=%b cnt=1", o_bit, o_fifo_cnt, exp_bits[3]);
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (o_bit_valid !== 1'b0) begin
                bad++;
                $display("FAIL freeze_valid%0d: got %b required 0", n, o_bit_valid);
            end
        end
        total++;
        if (obs_bits.size() != 3) begin
            bad++;
            $display("FAIL freeze_no_xfer: got %0d bits required 3", obs_bits.size());
        end
        en = 1'b1;
        #1;
        total++;
        if (o_bit_valid !== 1'b1 || o_bit !== exp_bits[3] || o_last !== 1'b0) begin
            bad++;
            $display("FAIL freeze_resume: valid=%b bit=%b last=%b required valid=1 bit=%b last=0",
                     o_bit_valid, o_bit, o_last, exp_bits[3]);
        end
        for (int n = 0; n < 20 && obs_bits.size() < 5; n++) step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 5 && k < obs_bits.size(); k++) begin
            total++;
            if (obs_bits[k] !== exp_bits[k]) begin
                bad++;
                $display("FAIL freeze_bit%0d: got %b required %b", k, obs_bits[k], exp_bits[k]);
            end
        end
        total++;
        if (o_overflow !== 1'b1 || o_fifo_cnt !== 2'd1) begin
            bad++;
            $display("FAIL pre_reset: ovf=%b cnt=%0d required 1 1", o_overflow, o_fifo_cnt);
        end
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if ({o_bit_valid, o_bit, o_last, o_overflow, o_busy} !== 5'b0 || o_fifo_cnt !== 2'd0) begin
            bad++;
            $display("FAIL midframe_reset: valid,bit,last,ovf,busy=%b cnt=%0d required 00000 0",
                     {o_bit_valid, o_bit, o_last, o_overflow, o_busy}, o_fifo_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [7:0] fr;
        bit         got [$];
        bit         gl  [$];
        bit         exp [$];
        fr = 8'($urandom);
        do_reset();
        for (int k = 0; k < 8; k++) exp.push_back(bit'((8'h01 >> k) & 8'd1));
        for (int k = 0; k < 8; k++) exp.push_back(bit'((fr >> k) & 8'd1));
        for (int c = 0; c < 30; c++) begin
            lsb_frame_valid = (c < 2);
            lsb_frame       = (c == 0) ? 8'h01 : fr;
            i_bit_ready     = 1'b1;
            en              = 1'b1;
            #1;
            if (lsb_bit_valid === 1'b1) begin
                got.push_back(lsb_bit);
                gl.push_back(lsb_last);
            end
            @(posedge clk);
            #1;
            lsb_frame_valid = 1'b0;
        end
        total++;
        if (got.size() != 16) begin
            bad++;
            $display("FAIL lsb_count: got %0d bits required 16", got.size());
        end
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            total++;
            if (got[k] !== exp[k] || gl[k] !== (k % 8 == 7)) begin
                bad++;
                $display("FAIL lsb_bit%0d: bit=%b last=%b required bit=%b last=%b",
                         k, got[k], gl[k], exp[k], (k % 8 == 7));
            end
        end
        total++;
        if (lsb_overflow !== 1'b0 || lsb_busy !== 1'b0 || lsb_fifo_cnt !== 2'd0) begin
            bad++;
            $display("FAIL lsb_end: ovf=%b busy=%b cnt=%0d required 0 0 0", lsb_overflow, lsb_busy, lsb_fifo_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ready_toggle();
        test_random_stream();
        test_overflow();
        test_enable_freeze();
        test_lsb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
